// File: rtl/data_axi_bridge_if.sv
// AXI4 single-beat read/write channel bundle between the data bridge and the interconnect.
// master = bridge side, slave = interconnect/memory side.
interface data_axi_bridge_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata_axi;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata_axi;
  logic [3:0]      wstrb_axi;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata_axi, wstrb_axi, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata_axi, wstrb_axi, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/data_axi_bridge.sv
// Uncached LSU/MMU data port to AXI4 single-beat bridge, one transaction outstanding; load >= 3 cycles.
// Upstream stalls via addr_ok only in IDLE; data_ok is an unthrottled one-cycle pulse.
module data_axi_bridge #(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [31:0]           addr,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [31:0]           rdata,
  output logic                  data_err,
  data_axi_bridge_if.master     axi
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        aw_done;
  logic        w_done;

  logic rd_fire;
  logic wr_fire;
  logic aw_now;
  logic w_now;

  assign addr_ok = !reset && req && (state == IDLE);
  assign rd_fire = !reset && (state == RD_DATA) && axi.rvalid;
  assign wr_fire = !reset && (state == WR_RESP) && axi.bvalid;

  assign data_ok  = rd_fire | wr_fire;
  assign data_err = rd_fire ? axi.rresp[1] : (wr_fire ? axi.bresp[1] : 1'b0);
  assign rdata    = rd_fire ? axi.rdata_axi : rdata_q;

  // A handshake landing this cycle counts as done, so the last one moves straight to WR_RESP.
  assign aw_now = aw_done | axi.awready;
  assign w_now  = w_done  | axi.wready;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arvalid = !reset && (state == RD_ADDR);
  assign axi.rready  = !reset && (state == RD_DATA);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = 2'b01;
  assign axi.awvalid = !reset && (state == WR_REQ) && !aw_done;

  assign axi.wdata_axi = wdata_q;
  assign axi.wstrb_axi = wstrb_q;
  assign axi.wlast     = 1'b1;
  assign axi.wvalid    = !reset && (state == WR_REQ) && !w_done;
  assign axi.bready    = !reset && (state == WR_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            // Size 3 has no meaning on a 32-bit bus; issue it as a word.
            size_q  <= (size == 2'd3) ? 2'd2 : size;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            state   <= we ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (axi.arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            rdata_q <= axi.rdata_axi;
            state   <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_now && w_now) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_now;
            w_done  <= w_now;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ids are fixed with a single outstanding transaction; only the error bit of resp matters.
  logic unused_sink;
  assign unused_sink = &{1'b0, axi.rid, axi.bid, axi.rresp[0], axi.bresp[0]};

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: bench plays the AXI slave cycle by cycle.
module tb_data_axi_bridge;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        data_err;

  int checks = 0;
  int errors = 0;

  data_axi_bridge_if #(.ID_W(4)) axi ();

  data_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr     (addr),
    .we       (we),
    .size     (size),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .rdata    (rdata),
    .data_err (data_err),
    .axi      (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after posedge; outputs are checked at the following negedge.
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.arready   = 1'b0;
    axi.rvalid    = 1'b0;
    axi.rdata_axi = 32'd0;
    axi.rresp     = 2'b00;
    axi.awready   = 1'b0;
    axi.wready    = 1'b0;
    axi.bvalid    = 1'b0;
    axi.bresp     = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b1;
    addr  = 32'd0;
    we    = 1'b0;
    size  = 2'd0;
    wstrb = 4'd0;
    wdata = 32'd0;
    axi.rid = 4'd1;
    axi.bid = 4'd1;
    slave_idle();

    to_neg();
    chk("rst_addr_ok", 32'(addr_ok), 32'd0);
    to_next();
    to_next();
    reset = 1'b0;
    req   = 1'b0;
    to_neg();
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid",  32'(axi.wvalid),  32'd0);
    chk("rst_rready",  32'(axi.rready),  32'd0);
    chk("rst_bready",  32'(axi.bready),  32'd0);
    chk("rst_data_ok", 32'(data_ok),     32'd0);
    chk("rst_addr_ok", 32'(addr_ok),     32'd0);

    // Word load, rvalid two cycles after the AR handshake cycle.
    to_next();
    req = 1'b1; addr = 32'h1C000010; we = 1'b0; size = 2'd2;
    to_neg();
    chk("ld_addr_ok", 32'(addr_ok), 32'd1);
    chk("ld_arvalid0", 32'(axi.arvalid), 32'd0);
    to_next();
    req = 1'b0; addr = 32'h0; axi.arready = 1'b1;
    to_neg();
    chk("ld_arvalid", 32'(axi.arvalid), 32'd1);
    chk("ld_araddr", axi.araddr, 32'h1C000010);
    chk("ld_arsize", 32'(axi.arsize), 32'd2);
    chk("ld_arlen", 32'(axi.arlen), 32'd0);
    chk("ld_arburst", 32'(axi.arburst), 32'd1);
    chk("ld_arid", 32'(axi.arid), 32'd1);
    to_next();
    axi.arready = 1'b0;
    to_neg();
    chk("ld_arvalid_off", 32'(axi.arvalid), 32'd0);
    chk("ld_rready", 32'(axi.rready), 32'd1);
    chk("ld_no_data_ok", 32'(data_ok), 32'd0);
    to_next();
    axi.rvalid = 1'b1; axi.rdata_axi = 32'hDEADBEEF; axi.rresp = 2'b00;
    to_neg();
    chk("ld_data_ok", 32'(data_ok), 32'd1);
    chk("ld_rdata", rdata, 32'hDEADBEEF);
    chk("ld_data_err", 32'(data_err), 32'd0);
    to_next();
    slave_idle();
    to_neg();
    chk("ld_pulse_end", 32'(data_ok), 32'd0);
    chk("ld_rdata_hold", rdata, 32'hDEADBEEF);
    chk("ld_rready_off", 32'(axi.rready), 32'd0);

    // Byte store, AW accepted before W.
    to_next();
    req = 1'b1; addr = 32'h1C000013; we = 1'b1; size = 2'd0;
    wstrb = 4'b1000; wdata = 32'hAAAAAAAA;
    to_neg();
    chk("st_addr_ok", 32'(addr_ok), 32'd1);
    to_next();
    req = 1'b0; wdata = 32'h0; wstrb = 4'h0; addr = 32'h0; axi.awready = 1'b1;
    to_neg();
    chk("st_awvalid", 32'(axi.awvalid), 32'd1);
    chk("st_wvalid", 32'(axi.wvalid), 32'd1);
    chk("st_awaddr", axi.awaddr, 32'h1C000013);
    chk("st_awsize", 32'(axi.awsize), 32'd0);
    chk("st_wlast", 32'(axi.wlast), 32'd1);
    chk("st_wdata", axi.wdata_axi, 32'hAAAAAAAA);
    chk("st_wstrb", 32'(axi.wstrb_axi), 32'h8);
    to_next();
    axi.awready = 1'b0;
    to_neg();
    chk("st_aw_dropped", 32'(axi.awvalid), 32'd0);
    chk("st_w_held", 32'(axi.wvalid), 32'd1);
    to_next();
    axi.wready = 1'b1;
    to_neg();
    chk("st_w_held3", 32'(axi.wvalid), 32'd1);
    chk("st_aw_still_off", 32'(axi.awvalid), 32'd0);
    chk("st_bready_early", 32'(axi.bready), 32'd0);
    to_next();
    axi.wready = 1'b0;
    to_neg();
    chk("st_bready", 32'(axi.bready), 32'd1);
    chk("st_w_off", 32'(axi.wvalid), 32'd0);
    chk("st_no_data_ok", 32'(data_ok), 32'd0);
    to_next();
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    to_neg();
    chk("st_data_ok", 32'(data_ok), 32'd1);
    chk("st_data_err", 32'(data_err), 32'd0);
    to_next();
    slave_idle();
    to_neg();
    chk("st_pulse_end", 32'(data_ok), 32'd0);
    chk("st_bready_off", 32'(axi.bready), 32'd0);

    // Word store with AW and W in the same cycle; SLVERR response.
    to_next();
    req = 1'b1; addr = 32'h1C000020; we = 1'b1; size = 2'd2;
    wstrb = 4'hF; wdata = 32'h12345678;
    to_neg();
    chk("sim_addr_ok", 32'(addr_ok), 32'd1);
    to_next();
    req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1;
    to_neg();
    chk("sim_awvalid", 32'(axi.awvalid), 32'd1);
    chk("sim_wvalid", 32'(axi.wvalid), 32'd1);
    chk("sim_awsize", 32'(axi.awsize), 32'd2);
    to_next();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10;
    to_neg();
    chk("sim_bready", 32'(axi.bready), 32'd1);
    chk("sim_aw_off", 32'(axi.awvalid), 32'd0);
    chk("sim_w_off", 32'(axi.wvalid), 32'd0);
    chk("sim_data_ok", 32'(data_ok), 32'd1);
    chk("sim_data_err", 32'(data_err), 32'd1);
    to_next();
    slave_idle();

    // Back-to-back loads with req held high.
    req = 1'b1; addr = 32'h1C000100; we = 1'b0; size = 2'd2;
    to_neg();
    chk("b2b_addr_ok1", 32'(addr_ok), 32'd1);
    to_next();
    axi.arready = 1'b1;
    to_neg();
    chk("b2b_arvalid1", 32'(axi.arvalid), 32'd1);
    chk("b2b_no_accept", 32'(addr_ok), 32'd0);
    to_next();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata_axi = 32'h11112222;
    to_neg();
    chk("b2b_data_ok1", 32'(data_ok), 32'd1);
    chk("b2b_rdata1", rdata, 32'h11112222);
    chk("b2b_no_ar_in_rd", 32'(axi.arvalid), 32'd0);
    chk("b2b_no_accept_resp", 32'(addr_ok), 32'd0);
    to_next();
    axi.rvalid = 1'b0; addr = 32'h1C000104;
    to_neg();
    chk("b2b_addr_ok2", 32'(addr_ok), 32'd1);
    to_next();
    req = 1'b0; axi.arready = 1'b1;
    to_neg();
    chk("b2b_araddr2", axi.araddr, 32'h1C000104);
    to_next();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata_axi = 32'h33334444; axi.rresp = 2'b11;
    to_neg();
    chk("b2b_data_ok2", 32'(data_ok), 32'd1);
    chk("b2b_rdata2", rdata, 32'h33334444);
    chk("b2b_decerr", 32'(data_err), 32'd1);
    to_next();
    slave_idle();

    // Stalled AR channel; size 3 issued as a word.
    req = 1'b1; addr = 32'h1C000200; we = 1'b0; size = 2'd3;
    to_neg();
    chk("stl_addr_ok", 32'(addr_ok), 32'd1);
    to_next();
    addr = 32'h1C000FF0; size = 2'd0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("stl_arvalid", 32'(axi.arvalid), 32'd1);
      chk("stl_araddr", axi.araddr, 32'h1C000200);
      chk("stl_arsize", 32'(axi.arsize), 32'd2);
      chk("stl_addr_ok", 32'(addr_ok), 32'd0);
      to_next();
    end
    req = 1'b0; axi.arready = 1'b1;
    to_neg();
    chk("stl_arvalid_hs", 32'(axi.arvalid), 32'd1);
    to_next();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata_axi = 32'h00000055;
    to_neg();
    chk("stl_data_ok", 32'(data_ok), 32'd1);
    chk("stl_rdata", rdata, 32'h00000055);
    to_next();
    slave_idle();

    // Reset while waiting in RD_DATA.
    req = 1'b1; addr = 32'h1C000300; size = 2'd2;
    to_neg();
    chk("rmid_addr_ok", 32'(addr_ok), 32'd1);
    to_next();
    req = 1'b0; axi.arready = 1'b1;
    to_neg();
    chk("rmid_arvalid", 32'(axi.arvalid), 32'd1);
    to_next();
    axi.arready = 1'b0;
    to_neg();
    chk("rmid_rready", 32'(axi.rready), 32'd1);
    to_next();
    reset = 1'b1; axi.rvalid = 1'b1; axi.rdata_axi = 32'h99999999;
    to_neg();
    chk("rmid_rst_data_ok", 32'(data_ok), 32'd0);
    chk("rmid_rst_rready", 32'(axi.rready), 32'd0);
    to_next();
    reset = 1'b0; req = 1'b1; addr = 32'h1C000400;
    to_neg();
    chk("rmid_idle_rready", 32'(axi.rready), 32'd0);
    chk("rmid_idle_data_ok", 32'(data_ok), 32'd0);
    chk("rmid_addr_ok", 32'(addr_ok), 32'd1);
    to_next();
    req = 1'b0; axi.rvalid = 1'b0; axi.arready = 1'b1;
    to_neg();
    chk("rmid_new_araddr", axi.araddr, 32'h1C000400);
    to_next();
    slave_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
